// File: rtl/resp_compactor.sv
// resp_compactor: folds one response beat per clock into a MISR and compares the final signature.
// Optional RESP_COMPACT_XMASK_EN adds resp_mask; masked bits contribute 0 to the signature.
module resp_compactor #(
    parameter int              WIDTH = 8,
    parameter int              SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SEED = 16'h0000,
    parameter int              CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [SIG_W-1:0] exp_sig,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
`ifdef RESP_COMPACT_XMASK_EN
    input  logic [WIDTH-1:0] resp_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] pat_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [SIG_W-1:0] sig_nx, exp_q, exp_nx, misr;
    logic [CNT_W-1:0] cnt_nx, cnt_inc, np_q, np_nx;
    logic             pass_nx;
    logic [WIDTH-1:0] data_m;

`ifdef RESP_COMPACT_XMASK_EN
    assign data_m = resp_data & ~resp_mask;
`else
    assign data_m = resp_data;
`endif

    assign misr    = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(data_m);
    assign cnt_inc = pat_cnt + CNT_W'(1);
    assign busy    = state == RUN;
    assign done    = state == DONE;

    always_comb begin
        state_nx = state;
        sig_nx   = sig;
        cnt_nx   = pat_cnt;
        np_nx    = np_q;
        exp_nx   = exp_q;
        pass_nx  = pass;
        if (start && state != RUN) begin
            // a zero-length run completes on the start edge itself
            np_nx    = num_pat;
            exp_nx   = exp_sig;
            sig_nx   = SEED;
            cnt_nx   = '0;
            state_nx = (num_pat == '0) ? DONE : RUN;
            pass_nx  = (num_pat == '0) && (SEED == exp_sig);
        end else if (state == RUN && resp_valid) begin
            sig_nx = misr;
            cnt_nx = cnt_inc;
            if (cnt_inc == np_q) begin
                state_nx = DONE;
                pass_nx  = misr == exp_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sig     <= SEED;
            pat_cnt <= '0;
            np_q    <= '0;
            exp_q   <= '0;
            pass    <= 1'b0;
        end else begin
            state   <= state_nx;
            sig     <= sig_nx;
            pat_cnt <= cnt_nx;
            np_q    <= np_nx;
            exp_q   <= exp_nx;
            pass    <= pass_nx;
        end
    end
endmodule

// File: tb/tb_resp_compactor.sv
// tb_resp_compactor: directed and randomized checks of resp_compactor against a polynomial-arithmetic model.
module tb_resp_compactor;
    logic        clk = 1'b0;
    logic        rst_n, start, resp_valid;
    logic [15:0] num_pat, exp_sig;
    logic [7:0]  resp_data;
`ifdef RESP_COMPACT_XMASK_EN
    logic [7:0]  resp_mask = 8'h00;
`endif
    logic        busy, done, pass, fb_busy, fb_done, fb_pass;
    logic [15:0] sig, pat_cnt, fb_sig, fb_cnt;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    resp_compactor u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pat(num_pat), .exp_sig(exp_sig),
        .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef RESP_COMPACT_XMASK_EN
        .resp_mask(resp_mask),
`endif
        .busy(busy), .done(done), .pass(pass), .sig(sig), .pat_cnt(pat_cnt)
    );

    resp_compactor #(.WIDTH(1), .SEED(16'h8000)) u_fb (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pat(num_pat), .exp_sig(exp_sig),
        .resp_valid(resp_valid), .resp_data(resp_data[0:0]),
`ifdef RESP_COMPACT_XMASK_EN
        .resp_mask(resp_mask[0:0]),
`endif
        .busy(fb_busy), .done(fb_done), .pass(fb_pass), .sig(fb_sig), .pat_cnt(fb_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // signature times x modulo x^16 + POLY, plus the new response
    function automatic logic [15:0] model(input logic [15:0] s, input logic [15:0] d);
        int t;
        t = int'(s) * 2;
        if (t >= 65536) t = t ^ 'h11021;
        return 16'(t) ^ d;
    endfunction

    initial begin
        logic [15:0] beats[$];
        logic [15:0] ms, ex;
        int          np;
        rst_n = 1'b0; start = 1'b1; resp_valid = 1'b1; resp_data = 8'hff; num_pat = 16'd5; exp_sig = 16'h0;
        tick(); tick();
        check("rst_sig", 32'(sig), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_pass", 32'(pass), 32'h0);
        check("rst_cnt", 32'(pat_cnt), 32'h0);
        check("rst_fb_sig", 32'(fb_sig), 32'h8000);
        rst_n = 1'b1; start = 1'b0; resp_valid = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'h0);

        num_pat = 16'd3; exp_sig = 16'h0005; start = 1'b1;
        tick(); start = 1'b0;
        check("start_busy", 32'(busy), 32'h1);
        check("start_sig", 32'(sig), 32'h0);
        resp_valid = 1'b1; resp_data = 8'h01; tick();
        check("b1_sig", 32'(sig), 32'h0001);
        check("b1_cnt", 32'(pat_cnt), 32'h1);
        resp_data = 8'h00; tick();
        check("b2_sig", 32'(sig), 32'h0002);
        check("b2_done", 32'(done), 32'h0);
        resp_data = 8'h01; tick();
        check("b3_sig", 32'(sig), 32'h0005);
        check("b3_done", 32'(done), 32'h1);
        check("b3_busy", 32'(busy), 32'h0);
        check("b3_pass", 32'(pass), 32'h1);
        check("b3_cnt", 32'(pat_cnt), 32'h3);
        resp_data = 8'hff; tick();
        check("done_hold_sig", 32'(sig), 32'h0005);
        check("done_hold_cnt", 32'(pat_cnt), 32'h3);
        resp_valid = 1'b0;

        exp_sig = 16'h0004; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1; resp_data = (i == 1) ? 8'h00 : 8'h01; tick();
            resp_valid = 1'b0;
            ms = (i == 0) ? 16'h1 : (i == 1) ? 16'h2 : 16'h5;
            if (i < 2) begin
                start = 1'b1; num_pat = 16'd1;
                for (int g = 0; g < 2; g++) begin
                    tick();
                    check("gap_sig", 32'(sig), 32'(ms));
                    check("gap_busy", 32'(busy), 32'h1);
                    check("gap_cnt", 32'(pat_cnt), 32'(i + 1));
                end
                start = 1'b0; num_pat = 16'd3;
            end
        end
        check("fail_sig", 32'(sig), 32'h0005);
        check("fail_done", 32'(done), 32'h1);
        check("fail_pass", 32'(pass), 32'h0);

        num_pat = 16'd1; exp_sig = 16'h1021; start = 1'b1;
        tick(); start = 1'b0;
        check("fb_seed", 32'(fb_sig), 32'h8000);
        resp_valid = 1'b1; resp_data = 8'h00; tick(); resp_valid = 1'b0;
        check("fb_sig", 32'(fb_sig), 32'h1021);
        check("fb_done", 32'(fb_done), 32'h1);
        check("fb_pass", 32'(fb_pass), 32'h1);
        check("fb_main_pass", 32'(pass), 32'h0);

        num_pat = 16'd0; exp_sig = 16'h0000; start = 1'b1;
        tick(); start = 1'b0;
        check("z_done", 32'(done), 32'h1);
        check("z_busy", 32'(busy), 32'h0);
        check("z_pass", 32'(pass), 32'h1);
        check("z_fb_pass", 32'(fb_pass), 32'h0);
        num_pat = 16'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("rs_busy", 32'(busy), 32'h1);
        check("rs_done", 32'(done), 32'h0);
        check("rs_sig", 32'(sig), 32'h0);
        check("rs_cnt", 32'(pat_cnt), 32'h0);

        num_pat = 16'd5; start = 1'b1;
        tick(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 8'h5a; tick(); resp_data = 8'hc3; tick(); resp_valid = 1'b0;
        check("mr_cnt", 32'(pat_cnt), 32'h2);
        check("mr_sig", 32'(sig), 32'(model(model(16'h0, 16'h5a), 16'hc3)));
        #2 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_sig", 32'(sig), 32'h0);
        check("ar_cnt", 32'(pat_cnt), 32'h0);
        check("ar_fb_sig", 32'(fb_sig), 32'h8000);
        rst_n = 1'b1;
        tick();

`ifdef RESP_COMPACT_XMASK_EN
        num_pat = 16'd1; exp_sig = 16'h0000; start = 1'b1;
        tick(); start = 1'b0;
        resp_valid = 1'b1; resp_data = 8'hxx; resp_mask = 8'hff; tick();
        resp_valid = 1'b0; resp_data = 8'h00; resp_mask = 8'h00;
        check("xm_sig", 32'(sig), 32'h0);
        check("xm_pass", 32'(pass), 32'h1);
        check("xm_fb_sig", 32'(fb_sig), 32'h1021);
`endif

        for (int r = 0; r < 8; r++) begin
            np = $urandom_range(1, 12);
            beats.delete();
            ms = 16'h0;
            for (int k = 0; k < np; k++) begin
                beats.push_back(16'($urandom_range(0, 255)));
                ms = model(ms, beats[k]);
            end
            ex = $urandom_range(0, 1) ? ms : 16'($urandom);
            num_pat = 16'(np); exp_sig = ex; start = 1'b1;
            tick(); start = 1'b0;
            ms = 16'h0;
            for (int k = 0; k < np; k++) begin
                while ($urandom_range(0, 2) == 0) begin
                    resp_valid = 1'b0; resp_data = 8'($urandom); tick();
                    check("rnd_gap_sig", 32'(sig), 32'(ms));
                end
                resp_valid = 1'b1; resp_data = 8'(beats[k]); tick();
                ms = model(ms, beats[k]);
                check("rnd_sig", 32'(sig), 32'(ms));
                check("rnd_cnt", 32'(pat_cnt), 32'(k + 1));
                check("rnd_done", 32'(done), 32'(k == np - 1));
            end
            resp_valid = 1'b0;
            check("rnd_pass", 32'(pass), 32'(ms == ex));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
